// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues INCR read bursts of 64-bit instruction pairs,
// buffers them in a pair queue for decode, and discards in-flight data after a redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          BURST_LEN  = 4,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [1:0]  arburst,
    output logic [2:0]  arsize,
    output logic [7:0]  arlen,
    input  logic        arready,
    output logic        rready,
    input  logic        rvalid,
    input  logic [63:0] rdata,
    input  logic        rlast,
    input  logic [1:0]  rresp,
    output logic        fq_valid,
    input  logic        fq_ready,
    output logic [31:0] fq_pc,
    output logic [63:0] fq_instr,
    output logic [1:0]  fq_mask,
    output logic        fq_err,
    output logic        fetch_busy
);
    localparam int               PTR_W       = $clog2(FIFO_DEPTH);
    localparam int               CNT_W       = PTR_W + 1;
    localparam logic [31:0]      BURST_BYTES = 32'(BURST_LEN * 8);
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BURST_CNT   = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, AR_REQ, DATA, DRAIN} state_t;

    state_t           state_reg, state_next;
    logic [31:0]      fetch_pc_reg;
    logic [31:0]      araddr_reg;
    logic [31:0]      beat_addr_reg;
    logic             err_halt_reg;
    logic             drain_flag_reg;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic [31:0] mem_pc    [FIFO_DEPTH];
    logic [63:0] mem_instr [FIFO_DEPTH];
    logic [1:0]  mem_mask  [FIFO_DEPTH];
    logic        mem_err   [FIFO_DEPTH];

    logic [CNT_W-1:0] free_entries;
    logic [31:0]      beat_next_addr;
    logic             beat_hs, push, pop, before_target;
    logic [1:0]       beat_mask;

    assign arburst      = 2'b01;
    assign arsize       = 3'b011;
    assign arlen        = 8'(BURST_LEN - 1);
    assign araddr       = araddr_reg;
    assign fetch_busy   = (state_reg != IDLE);

    assign free_entries   = DEPTH_CNT - count_reg;
    assign beat_hs        = rvalid && rready;
    assign beat_next_addr = beat_addr_reg + 32'd8;
    assign before_target  = (beat_next_addr <= fetch_pc_reg);
    assign beat_mask      = (fetch_pc_reg == beat_addr_reg + 32'd4) ? 2'b10 : 2'b11;
    // Anything handshaking in a redirect cycle belongs to the old stream.
    assign push = beat_hs && (state_reg == DATA) && !redirect_valid
                  && !err_halt_reg && !before_target;
    assign pop  = fq_valid && fq_ready && !redirect_valid;

    assign fq_valid = (count_reg != '0);
    assign fq_pc    = fq_valid ? mem_pc[rd_ptr_reg]    : '0;
    assign fq_instr = fq_valid ? mem_instr[rd_ptr_reg] : '0;
    assign fq_mask  = fq_valid ? mem_mask[rd_ptr_reg]  : '0;
    assign fq_err   = fq_valid ? mem_err[rd_ptr_reg]   : 1'b0;

    always_comb begin
        state_next = state_reg;
        arvalid    = 1'b0;
        rready     = 1'b0;
        case (state_reg)
            IDLE: begin
                // Whole burst is reserved up front so rready never has to stall.
                if (!err_halt_reg && !redirect_valid && free_entries >= BURST_CNT)
                    state_next = AR_REQ;
            end
            AR_REQ: begin
                arvalid = 1'b1;
                if (arready)
                    state_next = (drain_flag_reg || redirect_valid) ? DRAIN : DATA;
            end
            DATA: begin
                rready = 1'b1;
                if (rvalid && rlast)
                    state_next = IDLE;
                else if (redirect_valid)
                    state_next = DRAIN;
            end
            DRAIN: begin
                rready = 1'b1;
                if (rvalid && rlast)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            fetch_pc_reg   <= RESET_PC;
            araddr_reg     <= '0;
            beat_addr_reg  <= '0;
            err_halt_reg   <= 1'b0;
            drain_flag_reg <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            state_reg <= state_next;

            if (state_reg == IDLE && state_next == AR_REQ)
                araddr_reg <= fetch_pc_reg & ~(BURST_BYTES - 32'd1);

            if (state_reg == AR_REQ && arready) begin
                beat_addr_reg  <= araddr_reg;
                drain_flag_reg <= 1'b0;
            end else begin
                if (state_reg == AR_REQ && redirect_valid)
                    drain_flag_reg <= 1'b1;
                if (beat_hs)
                    beat_addr_reg <= beat_next_addr;
            end

            if (redirect_valid) begin
                fetch_pc_reg <= redirect_pc & ~32'd3;
                err_halt_reg <= 1'b0;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
            end else begin
                if (push) begin
                    fetch_pc_reg <= beat_next_addr;
                    wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
                    if (rresp != 2'b00)
                        err_halt_reg <= 1'b1;
                end
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + CNT_W'(1);
                    2'b01:   count_reg <= count_reg - CNT_W'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_reg]    <= beat_addr_reg;
            mem_instr[wr_ptr_reg] <= rdata;
            mem_mask[wr_ptr_reg]  <= beat_mask;
            mem_err[wr_ptr_reg]   <= (rresp != 2'b00);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 1-cycle burst memory model feeds the DUT,
// and each scenario task checks queue contents, AR traffic and drain behaviour.
module tb_instr_fetch_unit;
    localparam int BURST_LEN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect_valid, arready, fq_ready;
    logic [31:0] redirect_pc;
    logic        arvalid, rready, fq_valid, fq_err, fetch_busy;
    logic [31:0] araddr, fq_pc;
    logic [1:0]  arburst, fq_mask;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [63:0] fq_instr;
    logic        rvalid = 1'b0;
    logic        rlast  = 1'b0;
    logic [63:0] rdata  = '0;
    logic [1:0]  rresp  = '0;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(.RESET_PC(32'h0), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .arvalid(arvalid), .araddr(araddr), .arburst(arburst), .arsize(arsize), .arlen(arlen),
        .arready(arready), .rready(rready), .rvalid(rvalid), .rdata(rdata), .rlast(rlast),
        .rresp(rresp), .fq_valid(fq_valid), .fq_ready(fq_ready), .fq_pc(fq_pc),
        .fq_instr(fq_instr), .fq_mask(fq_mask), .fq_err(fq_err), .fetch_busy(fetch_busy)
    );

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] pair_at(input logic [31:0] a);
        return {instr_at(a + 32'd4), instr_at(a)};
    endfunction

    // Memory model: accepts one AR, then returns one beat per cycle starting next cycle.
    logic [31:0] mem_base = '0;
    int          mem_beat = 0;
    logic        mem_busy = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          err_beat = -1;
    logic [31:0] ar_log[$];
    int          r_count = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_busy <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rresp    <= 2'b00;
        end else begin
            if (rvalid && rready) begin
                r_count <= r_count + 1;
                if (rlast) begin
                    rvalid   <= 1'b0;
                    rlast    <= 1'b0;
                    mem_busy <= 1'b0;
                end else begin
                    rdata    <= pair_at(mem_base + 32'(8 * (mem_beat + 1)));
                    rresp    <= (mem_base == err_addr && mem_beat + 1 == err_beat) ? 2'b10 : 2'b00;
                    rlast    <= (mem_beat + 1 == BURST_LEN - 1);
                    mem_beat <= mem_beat + 1;
                end
            end
            if (!mem_busy && arvalid && arready) begin
                ar_log.push_back(araddr);
                mem_base <= araddr;
                mem_beat <= 0;
                mem_busy <= 1'b1;
                rvalid   <= 1'b1;
                rdata    <= pair_at(araddr);
                rresp    <= (araddr == err_addr && err_beat == 0) ? 2'b10 : 2'b00;
                rlast    <= 1'b0;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; arready = 1'b1; fq_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({arvalid, rready, fq_valid, fetch_busy, fq_err} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {arvalid, rready, fq_valid, fetch_busy, fq_err});
        end
        total++;
        if (araddr !== 32'h0) begin bad++; $display("FAIL reset_araddr got=%h want=0", araddr); end
        total++;
        if ({fq_pc, fq_instr, fq_mask} !== 98'h0) begin
            bad++; $display("FAIL reset_fq got pc=%h instr=%h mask=%b want zeros", fq_pc, fq_instr, fq_mask);
        end
        total++;
        if ({arburst, arsize, arlen} !== {2'b01, 3'b011, 8'd3}) begin
            bad++; $display("FAIL ar_consts got burst=%b size=%b len=%0d want 01/011/3", arburst, arsize, arlen);
        end
    endtask

    task automatic test_fill();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (arvalid !== 1'b1 || araddr !== 32'h0) begin
            bad++; $display("FAIL first_ar got valid=%b addr=%h want 1/0", arvalid, araddr);
        end
        repeat (30) @(negedge clk);
        total++;
        if (ar_log.size() != 2) begin
            bad++; $display("FAIL fill_ar_count got=%0d want=2", ar_log.size());
        end else begin
            total++;
            if (ar_log[0] !== 32'h0 || ar_log[1] !== 32'h20) begin
                bad++; $display("FAIL fill_ar_addr got=%h,%h want 0,20", ar_log[0], ar_log[1]);
            end
        end
        total++;
        if (arvalid !== 1'b0 || fetch_busy !== 1'b0) begin
            bad++; $display("FAIL full_no_issue got arvalid=%b busy=%b want 0/0", arvalid, fetch_busy);
        end
    endtask

    task automatic test_pop_refill();
        int n;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (fq_valid !== 1'b1 || fq_pc !== 32'(8 * i) || fq_instr !== pair_at(32'(8 * i))
                || fq_mask !== 2'b11 || fq_err !== 1'b0) begin
                bad++; $display("FAIL pop%0d got v=%b pc=%h instr=%h mask=%b err=%b want pc=%h",
                                i, fq_valid, fq_pc, fq_instr, fq_mask, fq_err, 32'(8 * i));
            end
            total++;
            if (arvalid !== 1'b0) begin bad++; $display("FAIL no_ar_low_free%0d got arvalid=%b want 0", i, arvalid); end
            fq_ready = 1'b1;
            @(negedge clk);
        end
        fq_ready = 1'b0;
        n = 0;
        while (arvalid !== 1'b1 && n < 5) begin @(negedge clk); n++; end
        total++;
        if (arvalid !== 1'b1 || araddr !== 32'h40) begin
            bad++; $display("FAIL refill_ar got valid=%b addr=%h want 1/40", arvalid, araddr);
        end
        repeat (10) @(negedge clk);
        total++;
        if (fq_pc !== 32'h20 || fetch_busy !== 1'b0 || arvalid !== 1'b0) begin
            bad++; $display("FAIL refill_full got pc=%h busy=%b arvalid=%b want 20/0/0", fq_pc, fetch_busy, arvalid);
        end
    endtask

    task automatic test_redirect_idle();
        int n;
        total++;
        if (fetch_busy !== 1'b0) begin bad++; $display("FAIL pre_redirect_idle got busy=%b want 0", fetch_busy); end
        redirect_valid = 1'b1; redirect_pc = 32'h10F;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if (fq_valid !== 1'b0 || arvalid !== 1'b0) begin
            bad++; $display("FAIL redirect_flush got fq_valid=%b arvalid=%b want 0/0", fq_valid, arvalid);
        end
        @(negedge clk);
        total++;
        if (arvalid !== 1'b1 || araddr !== 32'h100) begin
            bad++; $display("FAIL redirect_ar got valid=%b addr=%h want 1/100", arvalid, araddr);
        end
        n = 0;
        while (fq_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        total++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h108 || fq_mask !== 2'b10 || fq_instr !== pair_at(32'h108)) begin
            bad++; $display("FAIL partial_pair got v=%b pc=%h mask=%b instr=%h want 108/10", fq_valid, fq_pc, fq_mask, fq_instr);
        end
        fq_ready = 1'b1;
        @(negedge clk);
        fq_ready = 1'b0;
        total++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h110 || fq_mask !== 2'b11) begin
            bad++; $display("FAIL after_partial got v=%b pc=%h mask=%b want 110/11", fq_valid, fq_pc, fq_mask);
        end
    endtask

    task automatic test_redirect_mid_burst();
        int n, n0;
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        n = 0;
        while (!(fetch_busy === 1'b1 && araddr === 32'h300 && rvalid && rready) && n < 30) begin
            @(negedge clk); n++;
        end
        total++;
        if (!(araddr === 32'h300 && rvalid && rready)) begin
            bad++; $display("FAIL mid_burst_start got araddr=%h rvalid=%b rready=%b want 300/1/1", araddr, rvalid, rready);
        end
        @(negedge clk);
        total++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h300) begin
            bad++; $display("FAIL beat1_written got v=%b pc=%h want 1/300", fq_valid, fq_pc);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        n0 = r_count;
        @(negedge clk);
        redirect_valid = 1'b0;
        total++;
        if (fq_valid !== 1'b0 || rready !== 1'b1 || fetch_busy !== 1'b1) begin
            bad++; $display("FAIL drain_enter got fq_valid=%b rready=%b busy=%b want 0/1/1", fq_valid, rready, fetch_busy);
        end
        n = 0;
        while (fetch_busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        total++;
        if (r_count - n0 != 3 || fq_valid !== 1'b0 || fetch_busy !== 1'b0) begin
            bad++; $display("FAIL drain_beats got beats=%0d fq_valid=%b busy=%b want 3/0/0", r_count - n0, fq_valid, fetch_busy);
        end
        n = 0;
        while (arvalid !== 1'b1 && n < 5) begin @(negedge clk); n++; end
        total++;
        if (arvalid !== 1'b1 || araddr !== 32'h200) begin
            bad++; $display("FAIL post_drain_ar got valid=%b addr=%h want 1/200", arvalid, araddr);
        end
        n = 0;
        while (fq_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        total++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h200 || fq_mask !== 2'b11) begin
            bad++; $display("FAIL post_drain_pair got v=%b pc=%h mask=%b want 1/200/11", fq_valid, fq_pc, fq_mask);
        end
    endtask

    task automatic test_error();
        int n, n_ar;
        err_addr = 32'h400; err_beat = 1;
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        @(negedge clk);
        redirect_valid = 1'b0;
        n = 0;
        while (fq_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        total++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h400 || fq_err !== 1'b0) begin
            bad++; $display("FAIL err_pair1 got v=%b pc=%h err=%b want 1/400/0", fq_valid, fq_pc, fq_err);
        end
        fq_ready = 1'b1;
        @(negedge clk);
        fq_ready = 1'b0;
        total++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h408 || fq_err !== 1'b1 || fq_mask !== 2'b11) begin
            bad++; $display("FAIL err_pair2 got v=%b pc=%h err=%b mask=%b want 1/408/1/11", fq_valid, fq_pc, fq_err, fq_mask);
        end
        fq_ready = 1'b1;
        @(negedge clk);
        fq_ready = 1'b0;
        n_ar = ar_log.size();
        repeat (15) @(negedge clk);
        total++;
        if (fq_valid !== 1'b0 || arvalid !== 1'b0 || fetch_busy !== 1'b0 || ar_log.size() != n_ar) begin
            bad++; $display("FAIL err_halt got fq_valid=%b arvalid=%b busy=%b new_ars=%0d want 0/0/0/0",
                            fq_valid, arvalid, fetch_busy, ar_log.size() - n_ar);
        end
    endtask

    task automatic test_redirect_ar_stall();
        int n, n0;
        arready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        @(negedge clk);
        redirect_valid = 1'b0;
        n = 0;
        while (arvalid !== 1'b1 && n < 5) begin @(negedge clk); n++; end
        total++;
        if (arvalid !== 1'b1 || araddr !== 32'h500) begin
            bad++; $display("FAIL stall_ar got valid=%b addr=%h want 1/500", arvalid, araddr);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h600;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (arvalid !== 1'b1 || araddr !== 32'h500) begin
                bad++; $display("FAIL ar_hold%0d got valid=%b addr=%h want 1/500", i, arvalid, araddr);
            end
            @(negedge clk);
        end
        arready = 1'b1;
        n0 = r_count;
        @(negedge clk);
        n = 0;
        while (fetch_busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        total++;
        if (r_count - n0 != 4 || fq_valid !== 1'b0 || fetch_busy !== 1'b0) begin
            bad++; $display("FAIL stall_drain got beats=%0d fq_valid=%b busy=%b want 4/0/0", r_count - n0, fq_valid, fetch_busy);
        end
        n = 0;
        while (arvalid !== 1'b1 && n < 5) begin @(negedge clk); n++; end
        total++;
        if (arvalid !== 1'b1 || araddr !== 32'h600) begin
            bad++; $display("FAIL stall_next_ar got valid=%b addr=%h want 1/600", arvalid, araddr);
        end
        n = 0;
        while (fq_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        total++;
        if (fq_valid !== 1'b1 || fq_pc !== 32'h600 || fq_instr !== pair_at(32'h600)) begin
            bad++; $display("FAIL stall_pair got v=%b pc=%h instr=%h want 1/600", fq_valid, fq_pc, fq_instr);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pop_refill();
        test_redirect_idle();
        test_redirect_mid_burst();
        test_error();
        test_redirect_ar_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
